// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard control for the 5-stage datapath: tracks the producers in EX and MEM,
// registers the EX-stage operand mux selects and raises a combinational stall on a load-use dependency.
module fwd_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_use_imm,
    input  logic              flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall
);

    localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(ZERO_REG);

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;
    localparam logic [1:0] SEL_IMM   = 2'b11;

    // Shadow of the instructions in EX and MEM. The WB occupant needs no
    // shadow: its result is already written to the register file by the time a
    // dependent instruction could select it, so it never steers a mux.
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_regwrite;
    logic              ex_memread;

    logic              mem_valid;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_regwrite;

    logic              issue;
    logic              ex_is_load;

    assign issue = id_valid & ~stall & ~flush;

    // Stall is a function of the current EX occupant, so a reset (which
    // clears ex_valid) drops it immediately.
    assign ex_is_load = ex_valid & ex_memread & (ex_rd != ZERO_ADDR);

    always_comb begin
        stall = 1'b0;
        if (id_valid && ex_is_load) begin
            if (ex_rd == id_rn)
                stall = 1'b1;
            else if (!id_use_imm && (ex_rd == id_rm))
                stall = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_rd        <= '0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            mem_valid    <= 1'b0;
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
        end else begin
            mem_valid    <= ex_valid;
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;
            if (issue) begin
                ex_valid    <= 1'b1;
                ex_rd       <= id_rd;
                ex_regwrite <= id_regwrite;
                ex_memread  <= id_memread;
            end else begin
                ex_valid    <= 1'b0;
                ex_rd       <= '0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
            end
        end
    end

    // One select generator per ALU operand; gi=0 is A (rn), gi=1 is B (rm/imm).
    for (genvar gi = 0; gi < 2; gi++) begin : opnd_g
        logic [REG_AW-1:0] src;
        logic              use_imm;
        logic              ex_hit;
        logic              mem_hit;
        logic [1:0]        sel_next;
        logic [1:0]        sel_reg;

        if (gi == 0) begin : a_src_g
            assign src     = id_rn;
            assign use_imm = 1'b0;
        end else begin : b_src_g
            assign src     = id_rm;
            assign use_imm = id_use_imm;
        end

        assign ex_hit  = ex_valid & ex_regwrite & (ex_rd == src) & (src != ZERO_ADDR);
        assign mem_hit = mem_valid & mem_regwrite & (mem_rd == src) & (src != ZERO_ADDR);

        // The EX producer is younger than the MEM one, so it takes priority.
        always_comb begin
            sel_next = SEL_RF;
            if (use_imm)
                sel_next = SEL_IMM;
            else if (ex_hit)
                sel_next = SEL_EXMEM;
            else if (mem_hit)
                sel_next = SEL_MEMWB;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                sel_reg <= SEL_RF;
            else if (issue)
                sel_reg <= sel_next;
            else
                sel_reg <= SEL_RF;
        end
    end

    assign fwd_a_sel = opnd_g[0].sel_reg;
    assign fwd_b_sel = opnd_g[1].sel_reg;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed vector bench for fwd_hazard_ctrl: a table of ID-stage instructions with expected stall and
// registered selects, followed by hand-written reset-mid-stall sequences.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rn;
    logic [4:0] id_rm;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_memread;
    logic       id_use_imm;
    logic       flush;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       stall;

    int errors = 0;
    int checks = 0;

    fwd_hazard_ctrl #(.REG_AW(5), .ZERO_REG(31)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rn       (id_rn),
        .id_rm       (id_rm),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .id_use_imm  (id_use_imm),
        .flush       (flush),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .stall       (stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [4:0] rn;
        logic [4:0] rm;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       imm;
        logic       fl;
        logic       es;
        logic [1:0] ea;
        logic [1:0] eb;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid    = t.v;
        id_rn       = t.rn;
        id_rm       = t.rm;
        id_rd       = t.rd;
        id_regwrite = t.rw;
        id_memread  = t.mr;
        id_use_imm  = t.imm;
        flush       = t.fl;
    endtask

    initial begin
        //                v   rn  rm  rd  rw  mr imm  fl  es  ea     eb
        vq.push_back('{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0}); // 0 NOP
        vq.push_back('{1'b1, 5'd2,  5'd3,  5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0}); // 1 ADD X1
        vq.push_back('{1'b1, 5'd1,  5'd3,  5'd2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0}); // 2 SUB X2,X1,X3
        vq.push_back('{1'b1, 5'd7,  5'd8,  5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0}); // 3 ADD X1
        vq.push_back('{1'b0, 5'd1,  5'd1,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0}); // 4 NOP (fields match)
        vq.push_back('{1'b1, 5'd5,  5'd1,  5'd4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2}); // 5 ORR X4,X5,X1
        vq.push_back('{1'b1, 5'd9,  5'd10, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0}); // 6 ADD X1
        vq.push_back('{1'b1, 5'd11, 5'd12, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0}); // 7 ADD X1
        vq.push_back('{1'b1, 5'd1,  5'd1,  5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1}); // 8 AND X6,X1,X1
        vq.push_back('{1'b1, 5'd20, 5'd0,  5'd2,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd3}); // 9 LDUR X2
        vq.push_back('{1'b1, 5'd2,  5'd2,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0}); // 10 ADD X3,X2,X2 stalls
        vq.push_back('{1'b1, 5'd2,  5'd2,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2}); // 11 ADD X3 retried
        vq.push_back('{1'b1, 5'd13, 5'd14, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0}); // 12 ADD X31
        vq.push_back('{1'b1, 5'd31, 5'd31, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0}); // 13 SUB X5,X31,X31
        vq.push_back('{1'b1, 5'd15, 5'd0,  5'd31, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd3}); // 14 LDUR X31
        vq.push_back('{1'b1, 5'd31, 5'd31, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0}); // 15 ADD X7,X31,X31
        vq.push_back('{1'b1, 5'd7,  5'd7,  5'd8,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd3}); // 16 ADDI X8,X7 (rm=X7)
        vq.push_back('{1'b1, 5'd30, 5'd0,  5'd9,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd3}); // 17 LDUR X9
        vq.push_back('{1'b1, 5'd20, 5'd9,  5'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd3}); // 18 imm, rm=X9: no stall
        vq.push_back('{1'b1, 5'd10, 5'd23, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0}); // 19 ADD X11,X10 (no regwrite)
        vq.push_back('{1'b1, 5'd11, 5'd11, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0}); // 20 flushed dependent
        vq.push_back('{1'b1, 5'd11, 5'd0,  5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0}); // 21 ORR X13,X11,X0
        vq.push_back('{1'b1, 5'd24, 5'd0,  5'd14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd3}); // 22 LDUR X14
        vq.push_back('{1'b1, 5'd14, 5'd2,  5'd15, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0}); // 23 flush + stall
        vq.push_back('{1'b1, 5'd14, 5'd14, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2}); // 24 ADD X16,X14,X14

        drive('0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_stall", {1'b0, stall}, 2'd0);
        check("reset_a", fwd_a_sel, 2'd0);
        check("reset_b", fwd_b_sel, 2'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i]);
            #1;
            check($sformatf("vec%0d_stall", i), {1'b0, stall}, {1'b0, vq[i].es});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_a", i), fwd_a_sel, vq[i].ea);
            check($sformatf("vec%0d_b", i), fwd_b_sel, vq[i].eb);
            $display("vec %0d: stall=%0b a=%0d b=%0d (exp %0b %0d %0d)",
                     i, stall, fwd_a_sel, fwd_b_sel, vq[i].es, vq[i].ea, vq[i].eb);
        end

        // Reset while a load-use stall is pending, with a non-zero B select in flight.
        @(negedge clk);
        drive('{1'b1, 5'd20, 5'd0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0}); // LDUR X1
        @(posedge clk);
        #1;
        check("pre_rst_b", fwd_b_sel, 2'd3);
        @(negedge clk);
        drive('{1'b1, 5'd1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0}); // ADD X2,X1,X1
        #1;
        check("pre_rst_stall", {1'b0, stall}, 2'd1);
        reset = 1'b1;
        #1;
        check("rst_async_stall", {1'b0, stall}, 2'd0);
        check("rst_async_a", fwd_a_sel, 2'd0);
        check("rst_async_b", fwd_b_sel, 2'd0);
        $display("reset mid-stall: stall=%0b a=%0d b=%0d", stall, fwd_a_sel, fwd_b_sel);
        @(posedge clk);
        #1;
        check("rst_hold_stall", {1'b0, stall}, 2'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_stall", {1'b0, stall}, 2'd0);
        @(posedge clk);
        #1;
        check("post_rst_a", fwd_a_sel, 2'd0);
        check("post_rst_b", fwd_b_sel, 2'd0);
        $display("first after reset: stall=%0b a=%0d b=%0d", stall, fwd_a_sel, fwd_b_sel);

        // A following consumer of X2 sees the post-reset instruction in EX.
        @(negedge clk);
        drive('{1'b1, 5'd3, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0});
        @(posedge clk);
        #1;
        check("post_rst_fwd_a", fwd_a_sel, 2'd0);
        check("post_rst_fwd_b", fwd_b_sel, 2'd1);
        $display("post-reset forward: a=%0d b=%0d", fwd_a_sel, fwd_b_sel);

        @(negedge clk);
        drive('0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
